mem_ctrl: RTL and testbench
===========================

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; all state updates on posedge.
REQ-002 SHALL have ports: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: if_req in 1 fetch request; if_addr in 32 fetch byte address; if_flush in 1 abort fetch.
REQ-004 SHALL have ports: if_done out 1 one-cycle completion pulse; if_inst out 32 fetched word.
REQ-005 SHALL have ports: mem_req in 1; mem_we in 1 (1=store); mem_sel in MemSelBus; mem_addr in 32; mem_wdata in 32.
REQ-006 SHALL have ports: mem_done out 1 one-cycle pulse; mem_rdata out 32 raw load data, zero-extended.
REQ-007 SHALL have ports: ram_a out 32; ram_wr out 1; ram_dout out 8; ram_din in 8, byte for the address driven in the previous cycle.

Function
REQ-008 SHALL implement FSM states IDLE, READ, WRITE, DONE.
- Arbitration occurs only in IDLE.
- No preemption.
REQ-009 SHALL grant MEM over IF when both request in the same IDLE cycle; the IF request stays pending.
REQ-010 SHALL latch address, data, sel, we and requester at grant; later input changes are ignored until DONE.
REQ-011 SHALL set byte count N from mem_sel: MEM_BYTE=1, MEM_HALF=2, MEM_WORD=4; IF always uses N=4.
REQ-012 SHALL sequence a read granted in cycle 0 as follows:
- ram_a = addr+k in cycle 1+k, for k<N.
- Byte k is captured from ram_din in cycle 2+k.
- Done pulse with data in cycle N+2.
REQ-013 SHALL sequence a write granted in cycle 0 as follows:
- ram_wr=1, ram_a=addr+k, ram_dout=wdata[8k+7:8k] in cycle 1+k.
- mem_done in cycle N+1.
REQ-014 SHALL assemble bytes little-endian (byte 0 in bits 7:0) and zero unread upper bytes.
REQ-015 SHALL compute addr+k modulo 2^32 (wrap-around).
REQ-016 SHALL, in DONE, assert exactly one of if_done/mem_done for one cycle; rdata/inst hold until the next done.
REQ-017 SHALL, in DONE, not arbitrate; IDLE follows in the next cycle.
REQ-018 SHALL drive ram_a=0, ram_wr=0, ram_dout=0 whenever not in READ/WRITE.
REQ-019 SHALL treat mem_req with MEM_NOP as follows:
- Go to DONE without RAM access.
- mem_done in cycle 1, mem_rdata=0.
REQ-020 SHALL handle if_flush during an IF transaction:
- Move to IDLE in the next cycle.
- Suppress if_done.
- if_flush in IDLE blocks IF grant that cycle.
- MEM transactions are unaffected by if_flush.

Reset
REQ-021 SHALL on rst set state IDLE, all outputs 0 and pending captures cleared, effective the cycle after rst is sampled.
REQ-022 SHALL abort any transaction when rst occurs mid-operation:
- No done pulse.
- Bytes already written stay written.
- ram_wr=0 from the next cycle.

Configuration
REQ-023 SHALL support macro MEM_CTRL_IBUF_EN.
REQ-024 SHALL, with MEM_CTRL_IBUF_EN defined, hold a single-entry buffer {valid, addr, inst}:
- An IF request whose if_addr matches a valid entry goes IDLE->DONE with no RAM access (if_done in cycle 1).
- The buffer is filled on each completed fetch.
- It is invalidated by any completed MEM write and by rst.
REQ-025 SHALL, without the macro, contain no buffer logic; every fetch uses the RAM per REQ-012.

Structure
REQ-026 SHALL take MemSelBus, MEM_NOP/BYTE/HALF/WORD, ZeroWord, ZeroByte and state encodings from the shared defines file.
REQ-027 SHALL place the instruction buffer in sub-module mem_ctrl_ibuf, instantiated only under MEM_CTRL_IBUF_EN.

Verification
REQ-028 SHALL cover word load: RAM[0x100..0x103]=11,22,33,44, mem_req at cycle 0 -> ram_a 0x100..0x103 in cycles 1-4, mem_done cycle 6, mem_rdata=0x44332211.
REQ-029 SHALL cover half store: wdata 0x0000BEEF to 0x200 -> ram_wr cycles 1-2, ram_a 0x200/0x201, ram_dout EF/BE, mem_done cycle 3.
REQ-030 SHALL cover conflict: cycle 0 MEM byte read at 0x10 and IF at 0x0 -> mem_done cycle 3, IF granted cycle 4, ram_a 0x0 at cycle 5, if_done cycle 10.
REQ-031 SHALL cover flush/reset:
- IF granted cycle 0, if_flush cycle 2 -> IDLE cycle 3, no if_done.
- rst in cycle 2 of a word store -> ram_wr=0 cycle 3, no mem_done.
REQ-032 SHALL cover wrap: word load at 0xFFFFFFFE -> ram_a FFFFFFFE, FFFFFFFF, 00000000, 00000001.
REQ-033 SHALL cover IBUF: two fetches of 0x40 -> second if_done 1 cycle after grant with the macro, 6 without; an intervening store forces a RAM refetch.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the mem_ctrl slice: select encodings, constants,
// FSM state encoding and byte-lane helpers.
package mem_ctrl_pkg;

  localparam int MemSelBus = 2;

  localparam logic [MemSelBus-1:0] MEM_NOP  = 2'd0;
  localparam logic [MemSelBus-1:0] MEM_BYTE = 2'd1;
  localparam logic [MemSelBus-1:0] MEM_HALF = 2'd2;
  localparam logic [MemSelBus-1:0] MEM_WORD = 2'd3;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;
  localparam logic [7:0]  ZeroByte = 8'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic [2:0] sel_count(input logic [MemSelBus-1:0] sel);
    logic [2:0] n;
    case (sel)
      MEM_BYTE: n = 3'd1;
      MEM_HALF: n = 3'd2;
      MEM_WORD: n = 3'd4;
      default:  n = 3'd0;
    endcase
    return n;
  endfunction

  function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      2'd3:    b = w[31:24];
      default: b = ZeroByte;
    endcase
    return b;
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] idx,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    case (idx)
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      2'd2:    r[23:16] = b;
      2'd3:    r[31:24] = b;
      default: r = w;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_ctrl_ibuf.sv
// Single-entry instruction buffer {valid, addr, inst}; only present in builds
// with MEM_CTRL_IBUF_EN defined.
`ifdef MEM_CTRL_IBUF_EN
module mem_ctrl_ibuf (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] lookup_addr,
  input  logic        fill,
  input  logic [31:0] fill_addr,
  input  logic [31:0] fill_inst,
  input  logic        inval,
  output logic        hit,
  output logic [31:0] hit_inst
);

  logic        valid_r;
  logic [31:0] addr_r;
  logic [31:0] inst_r;

  // Entry update: stores kill the entry, completed fetches refill it.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= 1'b0;
      addr_r  <= 32'h0000_0000;
      inst_r  <= 32'h0000_0000;
    end else if (inval) begin
      valid_r <= 1'b0;
    end else if (fill) begin
      valid_r <= 1'b1;
      addr_r  <= fill_addr;
      inst_r  <= fill_inst;
    end
  end

  assign hit      = valid_r && (lookup_addr == addr_r);
  assign hit_inst = inst_r;

endmodule
`endif

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating fetch (IF) and load/store (MEM)
// ports onto an 8-bit RAM. Optional fetch buffer: MEM_CTRL_IBUF_EN.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if_req,
  input  logic [31:0]          if_addr,
  input  logic                 if_flush,
  output logic                 if_done,
  output logic [31:0]          if_inst,
  input  logic                 mem_req,
  input  logic                 mem_we,
  input  logic [MemSelBus-1:0] mem_sel,
  input  logic [31:0]          mem_addr,
  input  logic [31:0]          mem_wdata,
  output logic                 mem_done,
  output logic [31:0]          mem_rdata,
  output logic [31:0]          ram_a,
  output logic                 ram_wr,
  output logic [7:0]           ram_dout,
  input  logic [7:0]           ram_din
);

  state_t      state_r, state_next_s;
  logic [31:0] addr_r, wdata_r, asm_r, asm_next_s;
  logic [31:0] if_inst_r, mem_rdata_r;
  logic [2:0]  cnt_r, n_r;
  logic        is_if_r, if_done_r, mem_done_r;
  logic        grant_mem_s, grant_if_s;
  logic        flush_abort_s, read_last_s, write_last_s;
  logic        ibuf_hit_s;
  logic [31:0] ibuf_inst_s;

  assign flush_abort_s = (state_r == READ) && is_if_r && if_flush;
  assign read_last_s   = (state_r == READ) && !flush_abort_s && (cnt_r == n_r);
  assign write_last_s  = (state_r == WRITE) && (cnt_r == (n_r - 3'd1));

`ifdef MEM_CTRL_IBUF_EN
  mem_ctrl_ibuf u_ibuf (
    .clk         (clk),
    .rst         (rst),
    .lookup_addr (if_addr),
    .fill        (read_last_s && is_if_r),
    .fill_addr   (addr_r),
    .fill_inst   (asm_next_s),
    .inval       (write_last_s),
    .hit         (ibuf_hit_s),
    .hit_inst    (ibuf_inst_s)
  );
`else
  assign ibuf_hit_s  = 1'b0;
  assign ibuf_inst_s = ZeroWord;
`endif

  // Next-state and grant decode; MEM wins arbitration, which only happens in IDLE.
  always_comb begin
    state_next_s = state_r;
    grant_mem_s  = 1'b0;
    grant_if_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (mem_req) begin
          grant_mem_s = 1'b1;
          if (mem_sel == MEM_NOP) state_next_s = DONE;
          else if (mem_we)        state_next_s = WRITE;
          else                    state_next_s = READ;
        end else if (if_req && !if_flush) begin
          grant_if_s = 1'b1;
          if (ibuf_hit_s) state_next_s = DONE;
          else            state_next_s = READ;
        end else begin
          state_next_s = IDLE;
        end
      end
      READ: begin
        if (flush_abort_s)     state_next_s = IDLE;
        else if (read_last_s)  state_next_s = DONE;
        else                   state_next_s = READ;
      end
      WRITE: begin
        if (write_last_s) state_next_s = DONE;
        else              state_next_s = WRITE;
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Byte returned this cycle belongs to the address driven one cycle earlier.
  always_comb begin
    asm_next_s = asm_r;
    if (cnt_r != 3'd0) begin
      asm_next_s = put_byte(asm_r, cnt_r[1:0] - 2'd1, ram_din);
    end else begin
      asm_next_s = asm_r;
    end
  end

  // RAM port decode; quiet outside active transfer cycles.
  always_comb begin
    ram_a    = ZeroWord;
    ram_wr   = 1'b0;
    ram_dout = ZeroByte;
    if ((state_r == READ) && (cnt_r < n_r)) begin
      ram_a = addr_r + {29'd0, cnt_r};
    end else if (state_r == WRITE) begin
      ram_a    = addr_r + {29'd0, cnt_r};
      ram_wr   = 1'b1;
      ram_dout = get_byte(wdata_r, cnt_r[1:0]);
    end else begin
      ram_a = ZeroWord;
    end
  end

  // State register, transaction latch, byte assembly and done/data outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      addr_r      <= ZeroWord;
      wdata_r     <= ZeroWord;
      asm_r       <= ZeroWord;
      cnt_r       <= 3'd0;
      n_r         <= 3'd0;
      is_if_r     <= 1'b0;
      if_done_r   <= 1'b0;
      mem_done_r  <= 1'b0;
      if_inst_r   <= ZeroWord;
      mem_rdata_r <= ZeroWord;
    end else begin
      state_r    <= state_next_s;
      if_done_r  <= 1'b0;
      mem_done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          cnt_r <= 3'd0;
          asm_r <= ZeroWord;
          if (grant_mem_s) begin
            addr_r  <= mem_addr;
            wdata_r <= mem_wdata;
            n_r     <= sel_count(mem_sel);
            is_if_r <= 1'b0;
            if (mem_sel == MEM_NOP) begin
              mem_done_r  <= 1'b1;
              mem_rdata_r <= ZeroWord;
            end
          end else if (grant_if_s) begin
            addr_r  <= if_addr;
            wdata_r <= ZeroWord;
            n_r     <= 3'd4;
            is_if_r <= 1'b1;
            if (ibuf_hit_s) begin
              if_done_r <= 1'b1;
              if_inst_r <= ibuf_inst_s;
            end
          end
        end
        READ: begin
          if (flush_abort_s) begin
            cnt_r <= 3'd0;
          end else begin
            cnt_r <= cnt_r + 3'd1;
            asm_r <= asm_next_s;
            if (read_last_s) begin
              if (is_if_r) begin
                if_done_r <= 1'b1;
                if_inst_r <= asm_next_s;
              end else begin
                mem_done_r  <= 1'b1;
                mem_rdata_r <= asm_next_s;
              end
            end
          end
        end
        WRITE: begin
          cnt_r <= cnt_r + 3'd1;
          if (write_last_s) mem_done_r <= 1'b1;
        end
        DONE:    cnt_r <= 3'd0;
        default: cnt_r <= 3'd0;
      endcase
    end
  end

  assign if_done   = if_done_r;
  assign if_inst   = if_inst_r;
  assign mem_done  = mem_done_r;
  assign mem_rdata = mem_rdata_r;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed self-checking bench for mem_ctrl with a byte-wide RAM model that
// returns the byte for the previous cycle's address.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

`ifdef MEM_CTRL_IBUF_EN
  localparam int IbLat = 1;
`else
  localparam int IbLat = 6;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_flush, if_done;
  logic [31:0] if_addr, if_inst;
  logic        mem_req, mem_we, mem_done;
  logic [1:0]  mem_sel;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] ram_a;
  logic        ram_wr;
  logic [7:0]  ram_dout, ram_din;

  logic        poke_en;
  logic [11:0] poke_a;
  logic [7:0]  poke_d;
  logic [7:0]  ram [0:4095];

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mem_ctrl dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_done(if_done), .if_inst(if_inst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata),
    .ram_a(ram_a), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din)
  );

  always @(posedge clk) begin
    if (poke_en) ram[poke_a] <= poke_d;
    else if (ram_wr) ram[ram_a[11:0]] <= ram_dout;
    ram_din <= ram[ram_a[11:0]];
  end

  task automatic poke(input logic [11:0] a, input logic [7:0] d);
    @(negedge clk);
    poke_en = 1'b1; poke_a = a; poke_d = d;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  // Issues a fetch at cycle 0 and reports done cycle, word and cycle-1 ram_a.
  task automatic run_fetch(input logic [31:0] a, output int lat, output logic [31:0] inst,
                           output logic [31:0] a1);
    lat = -1; inst = 32'h0; a1 = 32'h0;
    @(negedge clk);
    if_req = 1'b1; if_addr = a;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) a1 = ram_a;
      if (if_done && lat < 0) begin
        lat = c; inst = if_inst; if_req = 1'b0;
      end
    end
    if_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (ram_a !== 32'h0) $display("FAIL reset_ram_a got %h want 0", ram_a); else passed++;
    total++; if (ram_wr !== 1'b0) $display("FAIL reset_ram_wr got %b want 0", ram_wr); else passed++;
    total++; if (ram_dout !== 8'h0) $display("FAIL reset_ram_dout got %h want 0", ram_dout); else passed++;
    total++; if (if_done !== 1'b0) $display("FAIL reset_if_done got %b want 0", if_done); else passed++;
    total++; if (mem_done !== 1'b0) $display("FAIL reset_mem_done got %b want 0", mem_done); else passed++;
    total++; if (mem_rdata !== 32'h0) $display("FAIL reset_mem_rdata got %h want 0", mem_rdata); else passed++;
    total++; if (if_inst !== 32'h0) $display("FAIL reset_if_inst got %h want 0", if_inst); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_word_load();
    int dc = -1, np = 0;
    logic [31:0] rd = 32'h0;
    poke(12'h100, 8'h11); poke(12'h101, 8'h22); poke(12'h102, 8'h33); poke(12'h103, 8'h44);
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b0; mem_sel = MEM_WORD; mem_addr = 32'h100;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c == 1) begin mem_req = 1'b0; mem_addr = 32'hDEAD_0000; mem_sel = MEM_BYTE; end
      if (c <= 4) begin
        total++;
        if (ram_a !== 32'h100 + 32'(c - 1)) $display("FAIL load_ram_a c%0d got %h want %h", c, ram_a, 32'h100 + 32'(c - 1));
        else passed++;
      end
      if (mem_done) begin np++; if (dc < 0) begin dc = c; rd = mem_rdata; end end
    end
    total++; if (dc != 6) $display("FAIL load_done_cycle got %0d want 6", dc); else passed++;
    total++; if (np != 1) $display("FAIL load_done_pulses got %0d want 1", np); else passed++;
    total++; if (rd !== 32'h4433_2211) $display("FAIL load_rdata got %h want 44332211", rd); else passed++;
  endtask

  task automatic test_half_store();
    int dc = -1;
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b1; mem_sel = MEM_HALF; mem_addr = 32'h200; mem_wdata = 32'h0000_BEEF;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) begin mem_req = 1'b0; mem_wdata = 32'h1234_5678; mem_addr = 32'h0; end
      if (c == 1) begin
        total++; if ({ram_wr, ram_a, ram_dout} !== {1'b1, 32'h200, 8'hEF})
          $display("FAIL store_c1 got wr=%b a=%h d=%h want 1/200/ef", ram_wr, ram_a, ram_dout); else passed++;
      end
      if (c == 2) begin
        total++; if ({ram_wr, ram_a, ram_dout} !== {1'b1, 32'h201, 8'hBE})
          $display("FAIL store_c2 got wr=%b a=%h d=%h want 1/201/be", ram_wr, ram_a, ram_dout); else passed++;
      end
      if (c == 3) begin
        total++; if (ram_wr !== 1'b0) $display("FAIL store_c3_wr got %b want 0", ram_wr); else passed++;
      end
      if (mem_done && dc < 0) dc = c;
    end
    total++; if (dc != 3) $display("FAIL store_done_cycle got %0d want 3", dc); else passed++;
    total++; if ({ram[12'h201], ram[12'h200]} !== 16'hBEEF)
      $display("FAIL store_ram got %h want beef", {ram[12'h201], ram[12'h200]}); else passed++;
  endtask

  task automatic test_conflict();
    int mc = -1, ic = -1;
    logic [31:0] rd = 32'h0, ins = 32'h0;
    poke(12'h010, 8'h5A);
    poke(12'h000, 8'h01); poke(12'h001, 8'h02); poke(12'h002, 8'h03); poke(12'h003, 8'h04);
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b0; mem_sel = MEM_BYTE; mem_addr = 32'h10;
    if_req = 1'b1; if_addr = 32'h0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c == 1) begin
        mem_req = 1'b0;
        total++; if (ram_a !== 32'h10) $display("FAIL conflict_mem_a got %h want 10", ram_a); else passed++;
      end
      if (c == 6) begin
        total++; if (ram_a !== 32'h1) $display("FAIL conflict_if_a1 got %h want 1", ram_a); else passed++;
      end
      if (mem_done && mc < 0) begin mc = c; rd = mem_rdata; end
      if (if_done && ic < 0) begin ic = c; ins = if_inst; if_req = 1'b0; end
    end
    if_req = 1'b0;
    total++; if (mc != 3) $display("FAIL conflict_mem_done got %0d want 3", mc); else passed++;
    total++; if (rd !== 32'h0000_005A) $display("FAIL conflict_rdata got %h want 0000005a", rd); else passed++;
    total++; if (ic != 10) $display("FAIL conflict_if_done got %0d want 10", ic); else passed++;
    total++; if (ins !== 32'h0403_0201) $display("FAIL conflict_inst got %h want 04030201", ins); else passed++;
  endtask

  task automatic test_flush();
    int nd = 0, na = 0;
    poke(12'h080, 8'hA0); poke(12'h081, 8'hA1); poke(12'h082, 8'hA2); poke(12'h083, 8'hA3);
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h80;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) if_req = 1'b0;
      if (c == 2) begin
        total++; if (ram_a !== 32'h81) $display("FAIL flush_pre_a got %h want 81", ram_a); else passed++;
        if_flush = 1'b1;
      end
      if (c == 3) begin
        total++; if (ram_a !== 32'h0) $display("FAIL flush_idle_a got %h want 0", ram_a); else passed++;
        if_flush = 1'b0;
      end
      if (if_done) nd++;
    end
    total++; if (nd != 0) $display("FAIL flush_if_done got %0d pulses want 0", nd); else passed++;
    @(negedge clk);
    if_req = 1'b1; if_flush = 1'b1; if_addr = 32'h80;
    @(negedge clk);
    if_req = 1'b0; if_flush = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (ram_a !== 32'h0) na++;
      if (if_done) nd++;
      @(negedge clk);
    end
    total++; if (na != 0 || nd != 0)
      $display("FAIL flush_idle_block got %0d ram cycles %0d dones want 0", na, nd); else passed++;
  endtask

  task automatic test_reset_mid_store();
    int nd = 0;
    poke(12'h302, 8'h00);
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b1; mem_sel = MEM_WORD; mem_addr = 32'h300; mem_wdata = 32'hA1B2_C3D4;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) begin
        mem_req = 1'b0;
        total++; if ({ram_wr, ram_dout} !== {1'b1, 8'hD4})
          $display("FAIL rststore_c1 got wr=%b d=%h want 1/d4", ram_wr, ram_dout); else passed++;
      end
      if (c == 2) rst = 1'b1;
      if (c == 3) begin
        total++; if ({ram_wr, ram_a} !== {1'b0, 32'h0})
          $display("FAIL rststore_c3 got wr=%b a=%h want 0/0", ram_wr, ram_a); else passed++;
        total++; if ({mem_rdata, if_inst} !== 64'h0)
          $display("FAIL rststore_data got %h/%h want 0/0", mem_rdata, if_inst); else passed++;
        rst = 1'b0;
      end
      if (mem_done) nd++;
    end
    total++; if (nd != 0) $display("FAIL rststore_done got %0d want 0", nd); else passed++;
    total++; if ({ram[12'h302], ram[12'h301], ram[12'h300]} !== 24'h00C3D4)
      $display("FAIL rststore_ram got %h want 00c3d4", {ram[12'h302], ram[12'h301], ram[12'h300]}); else passed++;
  endtask

  task automatic test_wrap();
    logic [31:0] exp_a [4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    int dc = -1;
    logic [31:0] rd = 32'h0;
    poke(12'hFFE, 8'hAA); poke(12'hFFF, 8'hBB); poke(12'h000, 8'hCC); poke(12'h001, 8'hDD);
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b0; mem_sel = MEM_WORD; mem_addr = 32'hFFFF_FFFE;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) mem_req = 1'b0;
      if (c <= 4) begin
        total++; if (ram_a !== exp_a[c-1])
          $display("FAIL wrap_a c%0d got %h want %h", c, ram_a, exp_a[c-1]); else passed++;
      end
      if (mem_done && dc < 0) begin dc = c; rd = mem_rdata; end
    end
    total++; if (dc != 6 || rd !== 32'hDDCC_BBAA)
      $display("FAIL wrap_done got cycle %0d data %h want 6 ddccbbaa", dc, rd); else passed++;
  endtask

  task automatic test_nop();
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b0; mem_sel = MEM_NOP; mem_addr = 32'h100;
    @(negedge clk);
    mem_req = 1'b0;
    total++; if ({mem_done, mem_rdata, ram_a} !== {1'b1, 32'h0, 32'h0})
      $display("FAIL nop_c1 got done=%b rdata=%h a=%h want 1/0/0", mem_done, mem_rdata, ram_a); else passed++;
    @(negedge clk);
    total++; if ({mem_done, ram_wr} !== 2'b00)
      $display("FAIL nop_c2 got done=%b wr=%b want 0/0", mem_done, ram_wr); else passed++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_ibuf();
    int lat;
    logic [31:0] ins, a1;
    poke(12'h040, 8'h10); poke(12'h041, 8'h20); poke(12'h042, 8'h30); poke(12'h043, 8'h40);
    run_fetch(32'h40, lat, ins, a1);
    total++; if (lat != 6 || ins !== 32'h4030_2010 || a1 !== 32'h40)
      $display("FAIL ibuf_first got lat=%0d inst=%h a=%h want 6/40302010/40", lat, ins, a1); else passed++;
    run_fetch(32'h40, lat, ins, a1);
    total++; if (lat != IbLat || ins !== 32'h4030_2010)
      $display("FAIL ibuf_second got lat=%0d inst=%h want %0d/40302010", lat, ins, IbLat); else passed++;
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b1; mem_sel = MEM_BYTE; mem_addr = 32'h40; mem_wdata = 32'h0000_0099;
    @(negedge clk);
    mem_req = 1'b0;
    repeat (3) @(negedge clk);
    run_fetch(32'h40, lat, ins, a1);
    total++; if (lat != 6 || ins !== 32'h4030_2099 || a1 !== 32'h40)
      $display("FAIL ibuf_refetch got lat=%0d inst=%h a=%h want 6/40302099/40", lat, ins, a1); else passed++;
  endtask

  initial begin
    rst = 1'b1; if_req = 1'b0; if_flush = 1'b0; if_addr = 32'h0;
    mem_req = 1'b0; mem_we = 1'b0; mem_sel = MEM_NOP; mem_addr = 32'h0; mem_wdata = 32'h0;
    poke_en = 1'b0; poke_a = 12'h0; poke_d = 8'h0;
    test_reset();
    test_word_load();
    test_half_store();
    test_conflict();
    test_flush();
    test_reset_mid_store();
    test_wrap();
    test_nop();
    test_ibuf();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
